regfile_param: RTL and testbench
================================

# regfile_param

Parametrised register file for the single-cycle CPU datapath. It has two combinational read ports and one synchronous write port, and sits between the decode stage and the ALU. After reset, or on request, it clears itself with a sequential sweep of one entry per cycle, so the storage maps onto RAM with no per-bit reset. Register 0 can optionally be hard-wired to zero, and write-to-read forwarding is a compile-time option.

## Interface
- DATA_W, 32, register width in bits
- ADDR_W, 5, address width; DEPTH = 2**ADDR_W entries
- ZERO_REG, 1, 1 = entry 0 reads as 0 and ignores writes; 0 = entry 0 is an ordinary register

- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- regwr  in  1  write enable
- WriteAddr  in  ADDR_W  write address
- WriteData  in  DATA_W  write data
- RsAddr  in  ADDR_W  read port A address
- RtAddr  in  ADDR_W  read port B address
- RsData  out  DATA_W  read port A data, combinational
- RtData  out  DATA_W  read port B data, combinational
- clr_req  in  1  request a full clear sweep; sampled in IDLE only
- busy  out  1  high while resetting or clearing
- wr_drop  out  1  one-cycle pulse when a write is discarded

## Operation
- FSM states: CLEAR and IDLE.
- Sweep counter `ptr` is ADDR_W bits wide.
- reset low:
  - state = CLEAR, ptr = 0, wr_drop = 0.
  - The array itself is not reset asynchronously.
- CLEAR, each clock edge:
  - entry[ptr] <= 0.
  - If ptr == DEPTH-1: go to IDLE and set ptr = 0.
  - Otherwise ptr <= ptr + 1.
- IDLE:
  - regwr = 1 writes WriteData into entry[WriteAddr].
  - With ZERO_REG = 1, a write to address 0 is silently ignored. It is not a drop and does not pulse wr_drop.
  - clr_req = 1 enters CLEAR on the next edge with ptr = 0.
  - If regwr and clr_req are both high in IDLE, the write completes on that edge, then the sweep starts.
- busy = (state == CLEAR). It is combinational from state and is 1 during and immediately after reset.
- Writes while busy:
  - A write with regwr = 1 while busy is discarded.
  - wr_drop = 1 for the following cycle only (registered).
- clr_req while busy: ignored; the sweep does not restart.
- Reads:
  - While busy, RsData and RtData = 0.
  - In IDLE, RsData = entry[RsAddr]; if ZERO_REG and RsAddr == 0, RsData = 0. RtData follows the same rule.
- Both read ports may address the same entry at once, with no restriction.

## Timing
- Read latency: 0 cycles (combinational from address).
- Write latency: data is visible on the read ports after the capturing rising edge.
- Sweep length: exactly DEPTH cycles from the first edge with reset high to busy = 0. This is 32 cycles at defaults.
- A reset assertion mid-sweep or mid-write aborts it immediately. The sweep restarts from ptr = 0 after release.
- Reset values:
  - busy = 1
  - wr_drop = 0
  - RsData = RtData = 0
- ptr wraps naturally at DEPTH-1. No other wrap-around exists.

## Configuration
- REGFILE_BYPASS_EN defined:
  - In IDLE, if regwr = 1 and WriteAddr == RsAddr, RsData = WriteData in the same cycle. RtData uses the same rule.
  - Forwarding is excluded for address 0 when ZERO_REG = 1.
  - Forwarding is never active while busy.
- REGFILE_BYPASS_EN undefined:
  - Reads return the stored value.
  - A same-cycle write becomes visible only after the edge.

## Test plan
- Reset, then release:
  - busy = 1 for exactly 32 cycles, then 0.
  - All 32 entries read 0 on both ports.
  - A write of 0xDEADBEEF to address 3 during the sweep gives wr_drop = 1 for one cycle, and entry 3 reads 0 afterwards.
- IDLE, write 0x12345678 to address 7, then set RsAddr = RtAddr = 7 -> both ports read 0x12345678 after the edge.
- ZERO_REG = 1, write 0xFFFFFFFF to address 0 -> RsData = 0 and wr_drop stays 0.
- Bypass:
  - Stimulus: regwr = 1, WriteAddr = RsAddr = 5, WriteData = 0xA5A5A5A5, with old entry[5] = 0x1.
  - With REGFILE_BYPASS_EN, RsData = 0xA5A5A5A5 in the same cycle.
  - Without it, RsData = 0x1, then 0xA5A5A5A5 after the edge.
- clr_req with a simultaneous write of 0x55 to address 9:
  - The write lands, then the sweep runs for 32 cycles.
  - After the sweep, entry 9 = 0.
  - A second clr_req mid-sweep does not extend the sweep.
- Reset pulse at sweep cycle 10 -> ptr restarts, and busy lasts 32 more cycles after release.

Source files
------------

// File: rtl/regfile_param.sv
// regfile_param
//
// Purpose:
//   Parametrised register file for the single-cycle CPU datapath, placed
//   between decode and the ALU. Two combinational read ports and one
//   synchronous write port. The storage array has no per-bit reset so it can
//   map onto RAM; instead a sweep clears one entry per clock after reset is
//   released, or after a clear request.
//
// Parameters:
//   DATA_W   - register width in bits
//   ADDR_W   - address width, DEPTH = 2**ADDR_W entries
//   ZERO_REG - 1: entry 0 reads as zero and ignores writes
//
// Ports:
//   clk        in   rising-edge clock
//   reset      in   asynchronous active-low reset
//   regwr      in   write enable
//   WriteAddr  in   write address
//   WriteData  in   write data
//   RsAddr     in   read port A address
//   RtAddr     in   read port B address
//   RsData     out  read port A data (combinational)
//   RtData     out  read port B data (combinational)
//   clr_req    in   request a clear sweep (honoured in IDLE only)
//   busy       out  high while the clear sweep is running
//   wr_drop    out  one-cycle pulse after a write was discarded while busy
//
// Compile-time option:
//   REGFILE_BYPASS_EN - forward same-cycle write data to the read ports.
module regfile_param #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              regwr,
    input  logic [ADDR_W-1:0] WriteAddr,
    input  logic [DATA_W-1:0] WriteData,
    input  logic [ADDR_W-1:0] RsAddr,
    input  logic [ADDR_W-1:0] RtAddr,
    output logic [DATA_W-1:0] RsData,
    output logic [DATA_W-1:0] RtData,
    input  logic              clr_req,
    output logic              busy,
    output logic              wr_drop
);

    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic {
        CLEAR = 1'b0,
        IDLE  = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic              wr_drop_q, wr_drop_d;
    logic [DATA_W-1:0] mem_q [DEPTH];

    logic              wrEn;
    logic              zeroRegOn;

    assign zeroRegOn = (ZERO_REG != 0);

    // A write is committed only in IDLE; writes to the hard-wired zero
    // register are swallowed here so they are neither stored nor dropped.
    assign wrEn = (state_q == IDLE) && regwr && !(zeroRegOn && (WriteAddr == '0));

    // State, sweep pointer and drop flag. Reset forces a fresh sweep from 0.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= CLEAR;
            ptr_q     <= '0;
            wr_drop_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            wr_drop_q <= wr_drop_d;
        end
    end

    // Next-state logic: CLEAR walks ptr through every entry, then hands over
    // to IDLE; IDLE re-enters CLEAR when a clear is requested.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        wr_drop_d = 1'b0;
        case (state_q)
            CLEAR: begin
                wr_drop_d = regwr;
                if (ptr_q == ADDR_W'(DEPTH - 1)) begin
                    state_d = IDLE;
                    ptr_d   = '0;
                end else begin
                    ptr_d = ptr_q + ADDR_W'(1);
                end
            end
            IDLE: begin
                if (clr_req) begin
                    state_d = CLEAR;
                    ptr_d   = '0;
                end
            end
            default: begin
                state_d = CLEAR;
                ptr_d   = '0;
            end
        endcase
    end

    // Storage array without reset. While a reset is held the state is CLEAR
    // with ptr at 0, so the only thing this can touch is zeroing entry 0.
    always_ff @(posedge clk) begin
        if (state_q == CLEAR) begin
            mem_q[ptr_q] <= '0;
        end else if (wrEn) begin
            mem_q[WriteAddr] <= WriteData;
        end
    end

    // Read ports: forced to zero while busy and for the zero register;
    // optional forwarding of the in-flight write.
    always_comb begin
        RsData = '0;
        RtData = '0;
        if (state_q == IDLE) begin
            RsData = mem_q[RsAddr];
            RtData = mem_q[RtAddr];
`ifdef REGFILE_BYPASS_EN
            if (wrEn && (WriteAddr == RsAddr)) begin
                RsData = WriteData;
            end
            if (wrEn && (WriteAddr == RtAddr)) begin
                RtData = WriteData;
            end
`endif
            if (zeroRegOn && (RsAddr == '0)) begin
                RsData = '0;
            end
            if (zeroRegOn && (RtAddr == '0)) begin
                RtData = '0;
            end
        end
    end

    assign busy    = (state_q == CLEAR);
    assign wr_drop = wr_drop_q;

endmodule

// File: tb/tb_regfile_param.sv
// tb_regfile_param
//
// Purpose:
//   Self-checking bench for regfile_param at default parameters. The stimulus
//   process drives inputs just after each rising edge and pushes the values
//   it expects into a scoreboard queue; a monitor process drains the queue on
//   every falling edge and compares against the live DUT outputs.
//   Expectations that depend on REGFILE_BYPASS_EN follow the same macro.
module tb_regfile_param;

   localparam int DATA_W = 32;
   localparam int ADDR_W = 5;

`ifdef REGFILE_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic              clk;
   logic              reset;
   logic              regwr;
   logic [ADDR_W-1:0] WriteAddr;
   logic [DATA_W-1:0] WriteData;
   logic [ADDR_W-1:0] RsAddr;
   logic [ADDR_W-1:0] RtAddr;
   logic [DATA_W-1:0] RsData;
   logic [DATA_W-1:0] RtData;
   logic              clr_req;
   logic              busy;
   logic              wr_drop;

   typedef enum int {K_RS, K_RT, K_BUSY, K_DROP} kind_t;

   typedef struct {
      string       name;
      kind_t       kind;
      logic [31:0] exp;
   } expect_t;

   expect_t     sbQ[$];
   expect_t     cur;
   logic [31:0] act;
   int          checkCount = 0;
   int          errorCount = 0;

   regfile_param #(
      .DATA_W  (DATA_W),
      .ADDR_W  (ADDR_W),
      .ZERO_REG(1)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .regwr    (regwr),
      .WriteAddr(WriteAddr),
      .WriteData(WriteData),
      .RsAddr   (RsAddr),
      .RtAddr   (RtAddr),
      .RsData   (RsData),
      .RtData   (RtData),
      .clr_req  (clr_req),
      .busy     (busy),
      .wr_drop  (wr_drop)
   );

   // Free-running 10 ns clock, rising edges at 5, 15, 25, ...
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Hard time limit so a stuck run still ends with a failure report.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish, checks=%0d errors=%0d",
               checkCount, errorCount + 1);
      $fatal(1, "[TB] watchdog expired");
   end

   // Monitor: on each falling edge compare every expectation queued during
   // the current cycle against what the DUT presents right now.
   always @(negedge clk) begin
      while (sbQ.size() > 0) begin
         cur = sbQ.pop_front();
         case (cur.kind)
            K_RS:    act = RsData;
            K_RT:    act = RtData;
            K_BUSY:  act = {31'b0, busy};
            default: act = {31'b0, wr_drop};
         endcase
         checkCount++;
         if (act !== cur.exp) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t",
                     cur.name, act, cur.exp, $time);
         end
      end
   end

   task automatic applyStimulus(input logic wr, input logic [ADDR_W-1:0] wa,
                                input logic [DATA_W-1:0] wd,
                                input logic [ADDR_W-1:0] ra,
                                input logic [ADDR_W-1:0] rb, input logic clr);
      regwr     = wr;
      WriteAddr = wa;
      WriteData = wd;
      RsAddr    = ra;
      RtAddr    = rb;
      clr_req   = clr;
   endtask

   task automatic checkOutput(input string name, input kind_t kind,
                              input logic [31:0] exp);
      expect_t e;
      e.name = name;
      e.kind = kind;
      e.exp  = exp;
      sbQ.push_back(e);
   endtask

   // Tally the outcome of a comparison made directly in the sequence.
   task automatic tallyDirect(input string name, input logic pass);
      checkCount++;
      if (!pass) begin
         errorCount++;
         $display("[TB] FAIL %s (direct check) at %0t", name, $time);
      end
   endtask

   task automatic stepEdge();
      @(posedge clk);
      #1;
   endtask

   // Directed sequence; each block below exercises one behaviour.
   initial begin
      reset = 1'b1;
      applyStimulus(1'b0, 5'd0, 32'h0, 5'd4, 5'd9, 1'b0);
      #2 reset = 1'b0;

      // Reset values held across a clock edge.
      stepEdge();
      tallyDirect("rst_busy_direct", busy === 1'b1);
      tallyDirect("rst_rs_direct", RsData === 32'h0);
      checkOutput("rst_busy", K_BUSY, 32'd1);
      checkOutput("rst_drop", K_DROP, 32'd0);
      checkOutput("rst_rs", K_RS, 32'h0);
      checkOutput("rst_rt", K_RT, 32'h0);
      @(negedge clk);
      #1 reset = 1'b1;

      // Initial sweep: busy for exactly 32 edges; a write mid-sweep drops.
      for (int k = 1; k <= 32; k++) begin
         stepEdge();
         checkOutput($sformatf("sweep1_busy_%0d", k), K_BUSY, {31'b0, (k < 32)});
         if (k == 5) applyStimulus(1'b1, 5'd3, 32'hDEADBEEF, 5'd3, 5'd3, 1'b0);
         if (k == 6) begin
            checkOutput("drop_pulse", K_DROP, 32'd1);
            checkOutput("busy_rs_zero", K_RS, 32'h0);
            applyStimulus(1'b0, 5'd0, 32'h0, 5'd3, 5'd3, 1'b0);
         end
         if (k == 7) checkOutput("drop_end", K_DROP, 32'd0);
      end
      tallyDirect("sweep1_done_direct", busy === 1'b0);

      // Every entry reads zero on both ports after the sweep.
      for (int a = 0; a < 32; a++) begin
         applyStimulus(1'b0, 5'd0, 32'h0, 5'(a), 5'(31 - a), 1'b0);
         checkOutput($sformatf("clr_rs_%0d", a), K_RS, 32'h0);
         checkOutput($sformatf("clr_rt_%0d", 31 - a), K_RT, 32'h0);
         stepEdge();
      end

      // Plain write to entry 7, read back on both ports.
      applyStimulus(1'b1, 5'd7, 32'h12345678, 5'd7, 5'd7, 1'b0);
      checkOutput("w7_rs_same", K_RS, BYP ? 32'h12345678 : 32'h0);
      checkOutput("w7_rt_same", K_RT, BYP ? 32'h12345678 : 32'h0);
      stepEdge();
      applyStimulus(1'b0, 5'd7, 32'h0, 5'd7, 5'd7, 1'b0);
      #1;
      tallyDirect("w7_rs_direct", RsData === 32'h12345678);
      checkOutput("w7_rs", K_RS, 32'h12345678);
      checkOutput("w7_rt", K_RT, 32'h12345678);
      checkOutput("w7_drop", K_DROP, 32'd0);

      // Zero register ignores writes and does not report a drop.
      stepEdge();
      applyStimulus(1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd7, 1'b0);
      checkOutput("z0_rs_same", K_RS, 32'h0);
      stepEdge();
      applyStimulus(1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 1'b0);
      checkOutput("z0_rs", K_RS, 32'h0);
      checkOutput("z0_rt", K_RT, 32'h0);
      checkOutput("z0_drop", K_DROP, 32'd0);

      // Same-cycle write/read on entry 5 holding 0x1.
      stepEdge();
      applyStimulus(1'b1, 5'd5, 32'h1, 5'd0, 5'd0, 1'b0);
      stepEdge();
      applyStimulus(1'b1, 5'd5, 32'hA5A5A5A5, 5'd5, 5'd5, 1'b0);
      checkOutput("byp_rs", K_RS, BYP ? 32'hA5A5A5A5 : 32'h1);
      checkOutput("byp_rt", K_RT, BYP ? 32'hA5A5A5A5 : 32'h1);
      stepEdge();
      applyStimulus(1'b0, 5'd5, 32'h0, 5'd5, 5'd7, 1'b0);
      checkOutput("byp_rs_after", K_RS, 32'hA5A5A5A5);
      checkOutput("byp_rt_keep7", K_RT, 32'h12345678);

      // Clear request together with a write; second request mid-sweep.
      stepEdge();
      applyStimulus(1'b1, 5'd12, 32'hCAFEF00D, 5'd12, 5'd0, 1'b0);
      stepEdge();
      applyStimulus(1'b1, 5'd9, 32'h55, 5'd9, 5'd12, 1'b1);
      checkOutput("clr_rs_same", K_RS, BYP ? 32'h55 : 32'h0);
      checkOutput("clr_rt_12", K_RT, 32'hCAFEF00D);
      checkOutput("clr_busy_pre", K_BUSY, 32'd0);
      for (int j = 1; j <= 33; j++) begin
         stepEdge();
         if (j == 1) begin
            applyStimulus(1'b0, 5'd9, 32'h0, 5'd9, 5'd12, 1'b0);
            checkOutput("clr_wr_nodrop", K_DROP, 32'd0);
         end
         if (j == 10) applyStimulus(1'b0, 5'd9, 32'h0, 5'd9, 5'd12, 1'b1);
         if (j == 11) applyStimulus(1'b0, 5'd9, 32'h0, 5'd9, 5'd12, 1'b0);
         checkOutput($sformatf("sweep2_busy_%0d", j), K_BUSY, {31'b0, (j < 33)});
      end
      tallyDirect("sweep2_done_direct", busy === 1'b0);
      checkOutput("clr_e9", K_RS, 32'h0);
      checkOutput("clr_e12", K_RT, 32'h0);

      // Reset pulse at sweep cycle 10 restarts a full 32-cycle sweep.
      stepEdge();
      applyStimulus(1'b1, 5'd20, 32'h0000BEEF, 5'd20, 5'd20, 1'b0);
      stepEdge();
      applyStimulus(1'b0, 5'd20, 32'h0, 5'd20, 5'd20, 1'b1);
      checkOutput("e20_written", K_RS, 32'h0000BEEF);
      stepEdge();
      applyStimulus(1'b0, 5'd20, 32'h0, 5'd20, 5'd20, 1'b0);
      for (int n = 2; n <= 10; n++) begin
         stepEdge();
         if (n == 9) applyStimulus(1'b1, 5'd20, 32'h1, 5'd20, 5'd20, 1'b0);
      end
      checkOutput("rst3_drop_pre", K_DROP, 32'd1);
      checkOutput("rst3_busy_pre", K_BUSY, 32'd1);
      @(negedge clk);
      #1;
      reset = 1'b0;
      applyStimulus(1'b0, 5'd20, 32'h0, 5'd20, 5'd20, 1'b0);
      #1;
      tallyDirect("rst3_busy_direct", busy === 1'b1);
      checkOutput("rst3_busy", K_BUSY, 32'd1);
      checkOutput("rst3_drop", K_DROP, 32'd0);
      checkOutput("rst3_rs", K_RS, 32'h0);
      @(negedge clk);
      #1 reset = 1'b1;
      for (int k = 1; k <= 32; k++) begin
         stepEdge();
         checkOutput($sformatf("sweep3_busy_%0d", k), K_BUSY, {31'b0, (k < 32)});
      end
      checkOutput("sweep3_e20", K_RS, 32'h0);
      checkOutput("sweep3_e20_rt", K_RT, 32'h0);

      @(negedge clk);
      #1;
      $display("[TB] Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
      $finish;
   end

endmodule
